fnd_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a multi-digit 7-segment (FND) display. It shares one `fnd_enc` hex-to-segment encoder across `N_DIGITS` common-anode digits by cycling a digit index at a divided refresh rate. It double-buffers the displayed value with frame-boundary update (no tearing) and inserts a blanking guard between digits against ghosting. It sits between the system's value producer and the board FND pins.

---
 rtl/fnd_pkg.sv | 14 +
 rtl/fnd_enc.sv | 28 ++
 rtl/fnd_scan_ctrl.sv | 149 ++++++++++++++
 tb/tb_fnd_scan_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared constants and scan-state encoding for the FND scan controller.
package fnd_pkg;

    localparam int unsigned MAX_DIGITS = 8;

    localparam logic [6:0]            SEG_OFF = 7'h7F;
    localparam logic [MAX_DIGITS-1:0] COM_OFF = '1;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_e;

endpackage

// File: rtl/fnd_enc.sv
// Hex nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}.
module fnd_enc (
    input  logic [3:0] din,
    output logic [6:0] dout
);

    always_comb begin
        case (din)
            4'h0:    dout = 7'h40;
            4'h1:    dout = 7'h79;
            4'h2:    dout = 7'h24;
            4'h3:    dout = 7'h30;
            4'h4:    dout = 7'h19;
            4'h5:    dout = 7'h12;
            4'h6:    dout = 7'h02;
            4'h7:    dout = 7'h58;
            4'h8:    dout = 7'h00;
            4'h9:    dout = 7'h10;
            4'hA:    dout = 7'h08;
            4'hB:    dout = 7'h03;
            4'hC:    dout = 7'h46;
            4'hD:    dout = 7'h21;
            4'hE:    dout = 7'h06;
            default: dout = 7'h0E;
        endcase
    end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Multiplexed FND scan controller: shared encoder, frame-boundary double
// buffering, per-slot blanking guard and leading-zero suppression.
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int unsigned N_DIGITS  = 4,
    parameter int unsigned CLK_DIV   = 50000,
    parameter int unsigned BLANK_CYC = 500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   blank_mask,
    input  logic                  lz_en,
    output logic [6:0]            seg,
    output logic [N_DIGITS-1:0]   com,
    output logic                  frame_done
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam int unsigned IDX_W = $clog2(N_DIGITS);
    localparam int unsigned VAL_W = 4 * N_DIGITS;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
    // State that belongs to div_cnt = 0; SHOW only when no blanking guard exists.
    localparam scan_state_e SLOT0_STATE = (BLANK_CYC == 0) ? SHOW : BLANK;

    scan_state_e          state_q, state_d;
    logic [DIV_W-1:0]     div_cnt, div_nxt;
    logic [IDX_W-1:0]     idx, idx_nxt;
    logic [VAL_W-1:0]     pending, shadow;
    logic                 pend_valid;

    logic                 fd_c;
    logic [6:0]           seg_c, enc_out;
    logic [N_DIGITS-1:0]  com_c;
    logic [3:0]           nib [N_DIGITS];
    logic [N_DIGITS-1:0]  lz_zero;
    logic                 zrun;
    logic                 dark;

    // State register and slot counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT0_STATE;
            div_cnt <= '0;
            idx     <= '0;
        end else begin
            state_q <= state_d;
            div_cnt <= div_nxt;
            idx     <= idx_nxt;
        end
    end

    // Next-state: slot counting, frame wrap, blank/show phase
    always_comb begin
        state_d = state_q;
        div_nxt = div_cnt;
        idx_nxt = idx;
        fd_c    = 1'b0;
        if (!en) begin
            div_nxt = '0;
            idx_nxt = '0;
            state_d = SLOT0_STATE;
        end else begin
            if (div_cnt == DIV_LAST) begin
                div_nxt = '0;
                if (idx == IDX_LAST) begin
                    idx_nxt = '0;
                    fd_c    = 1'b1;
                end else begin
                    idx_nxt = idx + IDX_W'(1);
                end
            end else begin
                div_nxt = div_cnt + DIV_W'(1);
            end
            state_d = (32'(div_nxt) < BLANK_CYC) ? BLANK : SHOW;
        end
    end

    // Display buffers: a load on the wrap cycle bypasses pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= '0;
            pend_valid <= 1'b0;
            shadow     <= '0;
        end else begin
            if (load) begin
                pending <= value;
            end
            if (fd_c) begin
                if (load) begin
                    shadow <= value;
                end else if (pend_valid) begin
                    shadow <= pending;
                end
                pend_valid <= 1'b0;
            end else if (load) begin
                pend_valid <= 1'b1;
            end
        end
    end

    // Nibble split and leading-zero run from the most significant digit down
    always_comb begin
        zrun    = 1'b1;
        lz_zero = '0;
        for (int k = 0; k < int'(N_DIGITS); k++) begin
            nib[k] = shadow[4*k +: 4];
        end
        for (int k = int'(N_DIGITS) - 1; k >= 0; k--) begin
            zrun       = zrun & (nib[k] == 4'h0);
            lz_zero[k] = zrun;
        end
    end

    assign dark = blank_mask[idx] | (lz_en & (idx != '0) & lz_zero[idx]);

    fnd_enc u_enc (
        .din  (nib[idx]),
        .dout (enc_out)
    );

    always_comb begin
        seg_c = SEG_OFF;
        com_c = COM_OFF[N_DIGITS-1:0];
        if (en && (state_q == SHOW) && !dark) begin
            seg_c      = enc_out;
            com_c[idx] = 1'b0;
        end
    end

    // Registered pin drivers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= SEG_OFF;
            com        <= COM_OFF[N_DIGITS-1:0];
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_c;
            com        <= com_c;
            frame_done <= fd_c;
        end
    end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Self-checking bench for fnd_scan_ctrl: expected pin frames are queued as
// stimulus is scheduled and compared cycle by cycle as the DUT drives them.
module tb_fnd_scan_ctrl;

    localparam int unsigned N   = 4;
    localparam int unsigned DIV = 8;
    localparam int unsigned BLK = 2;
    localparam int unsigned FRM = N * DIV;

    logic          clk = 1'b0;
    logic          rst_n, en, load, lz_en;
    logic [15:0]   value;
    logic [3:0]    blank_mask;
    logic [6:0]    seg;
    logic [3:0]    com;
    logic          frame_done;

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] com;
        logic       fd;
    } pins_t;

    pins_t exp_q[$];
    int    n_chk  = 0;
    int    n_pass = 0;
    string phase  = "init";

    localparam logic [6:0] ENC [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h58,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    fnd_scan_ctrl #(
        .N_DIGITS  (N),
        .CLK_DIV   (DIV),
        .BLANK_CYC (BLK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .value      (value),
        .blank_mask (blank_mask),
        .lz_en      (lz_en),
        .seg        (seg),
        .com        (com),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s.%s: got %0h expected %0h at %0t", phase, tag, got, exp, $time);
    endtask

    // Expected pins for window cycles lo..hi of a frame that starts at slot 0.
    task automatic push_frame(input logic [15:0] sh, input logic lz, input logic [3:0] mask,
                              input int lo, input int hi);
        pins_t      p;
        logic [3:0] nb, sel;
        bit         uz, drk;
        int         k, c;
        for (int j = lo; j <= hi; j++) begin
            k  = j / int'(DIV);
            c  = j % int'(DIV);
            nb = sh[4*k +: 4];
            uz = 1'b1;
            for (int m = k; m < int'(N); m++) if (sh[4*m +: 4] != 4'h0) uz = 1'b0;
            drk   = mask[k] || (lz && k != 0 && uz);
            p.seg = 7'h7F;
            p.com = 4'hF;
            p.fd  = (j == int'(FRM) - 1);
            if (c >= int'(BLK) && !drk) begin
                sel   = 4'b0001 << k;
                p.seg = ENC[nb];
                p.com = ~sel;
            end
            exp_q.push_back(p);
        end
    endtask

    task automatic push_dark(input int n);
        pins_t p;
        p.seg = 7'h7F;
        p.com = 4'hF;
        p.fd  = 1'b0;
        repeat (n) exp_q.push_back(p);
    endtask

    task automatic drain(input int n);
        pins_t p;
        repeat (n) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                chk("q_underrun", 32'(exp_q.size()), 1);
            end else begin
                p = exp_q.pop_front();
                chk("seg", 32'(seg), 32'(p.seg));
                chk("com", 32'(com), 32'(p.com));
                chk("frame_done", 32'(frame_done), 32'(p.fd));
            end
            chk("com_onehot", 32'($countones(~com) <= 1), 1);
        end
    endtask

    task automatic pulse_load(input logic [15:0] v);
        load  = 1'b1;
        value = v;
        drain(1);
        load  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; load = 1'b0; value = '0;
        blank_mask = '0; lz_en = 1'b0;
        repeat (3) @(negedge clk);
        phase = "reset";
        chk("seg", 32'(seg), 32'h7F);
        chk("com", 32'(com), 32'hF);
        chk("frame_done", 32'(frame_done), 0);
        rst_n = 1'b1;
        en    = 1'b1;

        // Reset asserted while digit 1 is lit
        phase = "mid_show_reset";
        for (int i = 0; i < 100 && com != 4'b1101; i++) @(negedge clk);
        chk("com_before", 32'(com), 32'hD);
        #1 rst_n = 1'b0;
        #1;
        chk("seg", 32'(seg), 32'h7F);
        chk("com", 32'(com), 32'hF);
        chk("frame_done", 32'(frame_done), 0);
        @(negedge clk);
        rst_n = 1'b1;

        phase = "f0_zero";
        push_frame(16'h0000, 1'b0, 4'h0, 0, FRM - 1);
        drain(6);
        pulse_load(16'h1234);
        drain(25);

        phase = "f1_1234";
        push_frame(16'h1234, 1'b0, 4'h0, 0, FRM - 1);
        drain(6);
        pulse_load(16'h0070);
        drain(25);
        lz_en = 1'b1;

        phase = "f2_lz";
        push_frame(16'h0070, 1'b1, 4'h0, 0, FRM - 1);
        drain(32);
        lz_en = 1'b0;

        phase = "f3_wrap_load";
        push_frame(16'h0070, 1'b0, 4'h0, 0, FRM - 1);
        drain(31);
        pulse_load(16'hAAAA);
        chk("pend_valid", 32'(dut.pend_valid), 0);
        chk("shadow", 32'(dut.shadow), 32'hAAAA);

        phase = "f4_aaaa";
        push_frame(16'hAAAA, 1'b0, 4'h0, 0, FRM - 1);
        drain(10);
        pulse_load(16'hBBBB);
        chk("pend_valid", 32'(dut.pend_valid), 1);
        drain(21);

        // Enable dropped mid slot 2 for 5 cycles, then a clean restart
        phase = "f5_en_drop";
        push_frame(16'hBBBB, 1'b0, 4'h0, 0, 18);
        push_dark(5);
        push_frame(16'hBBBB, 1'b0, 4'h0, 0, FRM - 1);
        drain(19);
        en = 1'b0;
        drain(5);
        en = 1'b1;
        drain(32);

        phase = "f6_bbbb";
        push_frame(16'hBBBB, 1'b0, 4'h0, 0, FRM - 1);
        drain(6);
        pulse_load(16'hFFFF);
        drain(25);
        blank_mask = 4'b0101;

        phase = "f7_mask";
        push_frame(16'hFFFF, 1'b0, 4'b0101, 0, FRM - 1);
        drain(32);

        phase = "end";
        chk("q_left", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
